// File: rtl/rr_interval_meter_pkg.sv
// Shared defaults and FSM state encoding for the R-R interval meter.
package rr_interval_meter_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int RR_LIMIT_DEF = 720;  // 2 s at 360 Hz
    localparam int REFRACT_DEF  = 72;   // 200 ms at 360 Hz

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRACT = 2'd1,
        ST_ARMED   = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

endpackage

// File: rtl/rr_interval_meter_if.sv
// Sample-in / interval-out bundle of the R-R interval meter.
interface rr_if #(
    parameter int CNT_W = 16
);
    logic             sample_en;
    logic             r_peak;
    logic [CNT_W-1:0] rr_data;
    logic             rr_valid;
    logic             rr_ready;
    logic             timeout;
    logic             overrun;

    // rr_valid/rr_ready: a transfer occurs on every rising clk edge where both
    // are high; once rr_valid is raised, rr_data stays stable until that edge.
    modport master (
        input  sample_en, r_peak, rr_ready,
        output rr_data, rr_valid, timeout, overrun
    );

    modport slave (
        output sample_en, r_peak, rr_ready,
        input  rr_data, rr_valid, timeout, overrun
    );
endinterface

// File: rtl/rr_avg4.sv
// Four-deep interval history with a running sum; only built with RR_AVG_EN.
`ifdef RR_AVG_EN
module rr_avg4 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic [W-1:0] avg
);
    logic [W-1:0] h0, h1, h2, h3;
    logic [W+1:0] sum_q;
    logic [W+1:0] sum_next;
    logic         seeded;

    // avg includes din combinationally so the caller can register it on push.
    always_comb begin
        sum_next = {din, 2'b00};
        if (seeded) begin
            sum_next = sum_q - {2'b00, h3} + {2'b00, din};
        end
    end

    assign avg = sum_next[W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            h0     <= '0;
            h1     <= '0;
            h2     <= '0;
            h3     <= '0;
            sum_q  <= '0;
            seeded <= 1'b0;
        end else if (push) begin
            sum_q <= sum_next;
            if (!seeded) begin
                h0     <= din;
                h1     <= din;
                h2     <= din;
                h3     <= din;
                seeded <= 1'b1;
            end else begin
                h3 <= h2;
                h2 <= h1;
                h1 <= h0;
                h0 <= din;
            end
        end
    end
endmodule
`endif

// File: rtl/rr_interval_meter.sv
// Measures R-R intervals in samples with refractory blanking and timeout.
// Define RR_AVG_EN to report the mean of the last four intervals instead.
module rr_interval_meter
    import rr_interval_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RR_LIMIT = RR_LIMIT_DEF,
    parameter int REFRACT  = REFRACT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    rr_if.master   bus,
    output state_t dbg_state
);
    if (REFRACT >= RR_LIMIT || longint'(RR_LIMIT) >= (longint'(1) << CNT_W)) begin : g_param_check
        $error("rr_interval_meter: need REFRACT < RR_LIMIT < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(RR_LIMIT);
    localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] interval;
    logic [CNT_W-1:0] data_next;
    logic [CNT_W-1:0] data_q;
    logic             valid_q;
    logic             timeout_q;
    logic             overrun_q;
    logic             peak;
    logic             cap;
    logic             load;

    assign peak     = bus.sample_en && bus.r_peak;
    assign cap      = (state == ST_ARMED) && peak;
    assign interval = cnt + CNT_W'(1);
    assign cnt_inc  = (cnt >= LIMIT_C) ? LIMIT_C : cnt + CNT_W'(1);
    // A capture is taken when the output slot is empty or being emptied this edge.
    assign load     = cap && (!valid_q || bus.rr_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (peak) begin
                        state <= ST_REFRACT;
                    end
                end
                ST_REFRACT: begin
                    if (bus.sample_en) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == REFRACT_C) begin
                            state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (peak) begin
                        cnt   <= '0;
                        state <= ST_REFRACT;
                    end else if (bus.sample_en) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == LIMIT_C) begin
                            state     <= ST_TIMEOUT;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_TIMEOUT: begin
                    if (peak) begin
                        cnt       <= '0;
                        timeout_q <= 1'b0;
                        state     <= ST_REFRACT;
                    end else if (bus.sample_en) begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef RR_AVG_EN
    rr_avg4 #(
        .W(CNT_W)
    ) u_avg (
        .clk (clk),
        .rst (rst),
        .push(load),
        .din (interval),
        .avg (data_next)
    );
`else
    assign data_next = interval;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (load) begin
                data_q  <= data_next;
                valid_q <= 1'b1;
            end else if (cap) begin
                overrun_q <= 1'b1;
            end else if (valid_q && bus.rr_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rr_data  = data_q;
    assign bus.rr_valid = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.overrun  = overrun_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_rr_interval_meter.sv
// Bench for rr_interval_meter: directed scenarios plus random stimulus vs a sample-index model.
module tb_rr_interval_meter;
    import rr_interval_meter_pkg::*;

    localparam int CNT_W    = 16;
    localparam int RR_LIMIT = 20;
    localparam int REFRACT  = 4;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    rr_if #(.CNT_W(CNT_W)) bus ();

    rr_interval_meter #(
        .CNT_W   (CNT_W),
        .RR_LIMIT(RR_LIMIT),
        .REFRACT (REFRACT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference: time measured as absolute sample indices since the last anchoring peak.
    bit               m_active;
    int               m_n;
    int               m_anchor;
    bit               m_valid;
    int               m_data;
    bit               m_timeout;
    bit               m_overrun;
    bit               m_seeded;
    int               hist[4];
    logic [CNT_W-1:0] exp_q[$];

    task automatic model_edge(input bit r, input bit se, input bit rp, input bit rdy);
        int el;
        bit cap;
        int ival;
        int val;
        bit pre_valid;
        cap = 1'b0;
        ival = 0;
        if (r) begin
            m_active = 0; m_n = 0; m_anchor = 0; m_valid = 0; m_data = 0;
            m_timeout = 0; m_overrun = 0; m_seeded = 0;
            exp_q.delete();
        end else begin
            pre_valid = m_valid;
            m_overrun = 0;
            if (se) begin
                m_n++;
                if (!m_active) begin
                    if (rp) begin
                        m_active = 1;
                        m_anchor = m_n;
                    end
                end else if (rp) begin
                    el = m_n - m_anchor;
                    if (el > REFRACT && el <= RR_LIMIT) begin
                        cap = 1;
                        ival = el;
                        m_anchor = m_n;
                    end else if (el > RR_LIMIT) begin
                        m_anchor = m_n;
                    end
                end
            end
            m_timeout = m_active && ((m_n - m_anchor) >= RR_LIMIT);
            if (cap) begin
                if (!pre_valid || rdy) begin
`ifdef RR_AVG_EN
                    if (!m_seeded) begin
                        for (int i = 0; i < 4; i++) hist[i] = ival;
                        m_seeded = 1;
                    end else begin
                        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                        hist[0] = ival;
                    end
                    val = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
                    val = ival;
`endif
                    m_data = val;
                    m_valid = 1;
                    exp_q.push_back(CNT_W'(val));
                end else begin
                    m_overrun = 1;
                end
            end else if (pre_valid && rdy) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit se, input bit rp, input bit rdy);
        rst = r;
        bus.sample_en = se;
        bus.r_peak = rp;
        bus.rr_ready = rdy;
        @(posedge clk);
        model_edge(r, se, rp, rdy);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 1);
        n_checks++;
        if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !== {1'b0, CNT_W'(0), 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%0b d=%0d t=%0b o=%0b, want all 0",
                     bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        int pulses = 0;
        cycle(1, 0, 0, 1);
        for (int s = 0; s < 16; s++) begin
            cycle(0, 1, (s == 0 || s == 10), 1);
            if (bus.rr_valid === 1'b1) pulses++;
            n_checks++;
            if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !==
                {m_valid, CNT_W'(m_data), m_timeout, m_overrun}) begin
                n_errors++;
                $display("FAIL basic s=%0d: got %h want %h", s,
                         {bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun},
                         {m_valid, CNT_W'(m_data), m_timeout, m_overrun});
            end
            if (s == 10) begin
                n_checks++;
                if (bus.rr_valid !== 1'b1 || bus.rr_data !== CNT_W'(10)) begin
                    n_errors++;
                    $display("FAIL basic_interval: got v=%0b d=%0d want v=1 d=10", bus.rr_valid, bus.rr_data);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL basic_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_refractory();
        cycle(1, 0, 0, 1);
        for (int s = 0; s < 13; s++) begin
            cycle(0, 1, (s == 0 || s == 2 || s == 9), 1);
            n_checks++;
            if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !==
                {m_valid, CNT_W'(m_data), m_timeout, m_overrun}) begin
                n_errors++;
                $display("FAIL refractory s=%0d: got %h want %h", s,
                         {bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun},
                         {m_valid, CNT_W'(m_data), m_timeout, m_overrun});
            end
            if (s == 9) begin
                n_checks++;
                if (bus.rr_valid !== 1'b1 || bus.rr_data !== CNT_W'(9)) begin
                    n_errors++;
                    $display("FAIL refractory_interval: got v=%0b d=%0d want v=1 d=9", bus.rr_valid, bus.rr_data);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int valids = 0;
        cycle(1, 0, 0, 1);
        for (int s = 0; s < 35; s++) begin
            cycle(0, 1, (s == 0 || s == 30), 1);
            if (bus.rr_valid === 1'b1) valids++;
            n_checks++;
            if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !==
                {m_valid, CNT_W'(m_data), m_timeout, m_overrun}) begin
                n_errors++;
                $display("FAIL timeout s=%0d: got %h want %h", s,
                         {bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun},
                         {m_valid, CNT_W'(m_data), m_timeout, m_overrun});
            end
            if (s == 19 || s == 20 || s == 30) begin
                n_checks++;
                if (bus.timeout !== (s == 20)) begin
                    n_errors++;
                    $display("FAIL timeout_flag s=%0d: got %0b want %0b", s, bus.timeout, (s == 20));
                end
            end
        end
        n_checks++;
        if (valids != 0) begin
            n_errors++;
            $display("FAIL timeout_no_interval: got %0d valid cycles want 0", valids);
        end
    endtask

    task automatic test_overrun();
        int overruns = 0;
        cycle(1, 0, 0, 0);
        for (int s = 0; s < 21; s++) begin
            cycle(0, 1, (s == 0 || s == 8 || s == 16), 0);
            if (bus.overrun === 1'b1) overruns++;
            n_checks++;
            if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !==
                {m_valid, CNT_W'(m_data), m_timeout, m_overrun}) begin
                n_errors++;
                $display("FAIL overrun s=%0d: got %h want %h", s,
                         {bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun},
                         {m_valid, CNT_W'(m_data), m_timeout, m_overrun});
            end
        end
        n_checks++;
        if (overruns != 1 || bus.rr_valid !== 1'b1 || bus.rr_data !== CNT_W'(8)) begin
            n_errors++;
            $display("FAIL overrun_hold: got pulses=%0d v=%0b d=%0d want pulses=1 v=1 d=8",
                     overruns, bus.rr_valid, bus.rr_data);
        end
        cycle(0, 1, 0, 1);
        n_checks++;
        if (bus.rr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_drain: got v=%0b want 0", bus.rr_valid);
        end
    endtask

    task automatic test_reset_mid();
        int valids = 0;
        cycle(1, 0, 0, 0);
        for (int s = 0; s < 12; s++) cycle(0, 1, (s == 0 || s == 8), 0);
        n_checks++;
        if (bus.rr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_pre: got v=%0b want 1", bus.rr_valid);
        end
        cycle(1, 1, 1, 0);
        n_checks++;
        if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !== {1'b0, CNT_W'(0), 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got v=%0b d=%0d t=%0b o=%0b want all 0",
                     bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun);
        end
        for (int s = 0; s < 8; s++) begin
            cycle(0, 1, (s == 0), 1);
            if (bus.rr_valid === 1'b1) valids++;
        end
        n_checks++;
        if (valids != 0) begin
            n_errors++;
            $display("FAIL reset_mid_first_peak: got %0d valid cycles want 0", valids);
        end
    endtask

`ifdef RR_AVG_EN
    task automatic test_avg();
        int want[4] = '{8, 8, 8, 9};
        int k = 0;
        cycle(1, 0, 0, 1);
        for (int s = 0; s < 40; s++) begin
            cycle(0, 1, (s == 0 || s == 8 || s == 16 || s == 24 || s == 36), 1);
            if (bus.rr_valid === 1'b1 && k < 4) begin
                n_checks++;
                if (bus.rr_data !== CNT_W'(want[k])) begin
                    n_errors++;
                    $display("FAIL avg_out%0d: got %0d want %0d", k, bus.rr_data, want[k]);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 4) begin
            n_errors++;
            $display("FAIL avg_count: got %0d outputs want 4", k);
        end
    endtask
`endif

    task automatic test_random();
        bit se, rp, rdy, r;
        logic [CNT_W-1:0] want;
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 399) == 0);
            se  = ($urandom_range(0, 3) != 0);
            rp  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (bus.rr_valid === 1'b1 && rdy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL random_xfer i=%0d: got d=%0d with no expected interval queued", i, bus.rr_data);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.rr_data !== want) begin
                        n_errors++;
                        $display("FAIL random_xfer i=%0d: got d=%0d want %0d", i, bus.rr_data, want);
                    end
                end
            end
            cycle(r, se, rp, rdy);
            n_checks++;
            if ({bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun} !==
                {m_valid, CNT_W'(m_data), m_timeout, m_overrun}) begin
                n_errors++;
                $display("FAIL random i=%0d: got %h want %h", i,
                         {bus.rr_valid, bus.rr_data, bus.timeout, bus.overrun},
                         {m_valid, CNT_W'(m_data), m_timeout, m_overrun});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.sample_en = 1'b0;
        bus.r_peak = 1'b0;
        bus.rr_ready = 1'b0;
        test_reset();
        test_basic();
        test_refractory();
        test_timeout();
        test_overrun();
        test_reset_mid();
`ifdef RR_AVG_EN
        test_avg();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
